// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-master APB arbiter.
//   state_e      : arbiter FSM states (IDLE -> SETUP -> ACCESS -> IDLE)
//   *_DEF        : default address width, data width and slave timeout
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/apb_arbiter_rr_pick2.sv
// Two-way round-robin picker with its last-granted pointer.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   req_i[1:0]    : request from master 1 / master 0
//   update_i      : a grant is being taken this cycle (pointer moves if any request)
//   grant_o       : index of the chosen master (0 or 1)
//   any_o         : at least one request present
module rr_pick2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       grant_o,
  output logic       any_o
);

  logic last_q, last_d;

  always_comb begin
    any_o = |req_i;
    // On a tie the master that was not granted last wins; otherwise the sole requester.
    if (&req_i) grant_o = ~last_q;
    else        grant_o = req_i[1];
    last_d = last_q;
    if (update_i && any_o) last_d = grant_o;
  end

  // Pointer starts at master 1 so master 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/apb_arbiter.sv
// Arbiter sharing one APB slave between two APB requesters.
//   PCLK, PRESETn           : clock, asynchronous active-low reset
//   mN_PSEL/PENABLE/PWRITE  : requester N controls (PENABLE is not needed for arbitration)
//   mN_PADDR/PWDATA         : requester N address / write data
//   mN_PRDATA/PREADY/PSLVERR: response to requester N (zero unless N completes)
//   s_PSEL/PENABLE/PWRITE/PADDR/PWDATA : shared slave request
//   s_PRDATA/PREADY         : shared slave response
// A slave stalling TIMEOUT access cycles is cut off and the requester gets PSLVERR.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              m0_PSEL,
  input  logic              m0_PENABLE,
  input  logic              m0_PWRITE,
  input  logic [ADDR_W-1:0] m0_PADDR,
  input  logic [DATA_W-1:0] m0_PWDATA,
  output logic [DATA_W-1:0] m0_PRDATA,
  output logic              m0_PREADY,
  output logic              m0_PSLVERR,
  input  logic              m1_PSEL,
  input  logic              m1_PENABLE,
  input  logic              m1_PWRITE,
  input  logic [ADDR_W-1:0] m1_PADDR,
  input  logic [DATA_W-1:0] m1_PWDATA,
  output logic [DATA_W-1:0] m1_PRDATA,
  output logic              m1_PREADY,
  output logic              m1_PSLVERR,
  output logic              s_PSEL,
  output logic              s_PENABLE,
  output logic              s_PWRITE,
  output logic [ADDR_W-1:0] s_PADDR,
  output logic [DATA_W-1:0] s_PWDATA,
  input  logic [DATA_W-1:0] s_PRDATA,
  input  logic              s_PREADY
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                drop_q, drop_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;

  logic                pick, any_req, gnt_psel, timed_out;
  logic                rsp_vld, rsp_err;
  logic [DATA_W-1:0]   rsp_data;
  logic                unused_penable;

  // Requester PENABLE carries no information the arbiter needs.
  assign unused_penable = m0_PENABLE ^ m1_PENABLE;

  rr_pick2 u_rr (
    .clk_i    (PCLK),
    .rst_ni   (PRESETn),
    .req_i    ({m1_PSEL, m0_PSEL}),
    .update_i (state_q == ST_IDLE),
    .grant_o  (pick),
    .any_o    (any_req)
  );

  assign gnt_psel  = gnt_q ? m1_PSEL : m0_PSEL;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    s_PSEL    = 1'b0;
    s_PENABLE = 1'b0;
    s_PWRITE  = 1'b0;
    s_PADDR   = '0;
    s_PWDATA  = '0;
    rsp_vld   = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        drop_d = 1'b0;
        if (any_req) begin
          gnt_d   = pick;
          addr_d  = pick ? m1_PADDR  : m0_PADDR;
          wdata_d = pick ? m1_PWDATA : m0_PWDATA;
          write_d = pick ? m1_PWRITE : m0_PWRITE;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        s_PSEL   = 1'b1;
        s_PWRITE = write_q;
        s_PADDR  = addr_q;
        s_PWDATA = wdata_q;
        // A requester that lets go of PSEL forfeits the response; the slave side carries on.
        if (!gnt_psel) drop_d = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        s_PWRITE = write_q;
        s_PADDR  = addr_q;
        s_PWDATA = wdata_q;
        if (!gnt_psel) drop_d = 1'b1;
        if (timed_out) begin
          // Forced completion: slave deselected, error returned with zero data.
          rsp_vld = 1'b1;
          rsp_err = 1'b1;
          state_d = ST_IDLE;
        end else begin
          s_PSEL    = 1'b1;
          s_PENABLE = 1'b1;
          if (s_PREADY) begin
            rsp_vld  = 1'b1;
            rsp_data = s_PRDATA;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response routing: only the granted requester, and only if it is still selecting.
  always_comb begin
    m0_PREADY  = 1'b0;
    m0_PRDATA  = '0;
    m0_PSLVERR = 1'b0;
    m1_PREADY  = 1'b0;
    m1_PRDATA  = '0;
    m1_PSLVERR = 1'b0;
    if (rsp_vld && !drop_q && gnt_psel) begin
      if (gnt_q) begin
        m1_PREADY  = 1'b1;
        m1_PRDATA  = rsp_data;
        m1_PSLVERR = rsp_err;
      end else begin
        m0_PREADY  = 1'b1;
        m0_PRDATA  = rsp_data;
        m0_PSLVERR = rsp_err;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched request fields; only observable outside IDLE, after they are loaded.
  always_ff @(posedge PCLK) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    write_q <= write_d;
  end

endmodule

// File: tb/tb_apb_arbiter.sv
module tb_apb_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          m0_PSEL, m0_PENABLE, m0_PWRITE, m0_PREADY, m0_PSLVERR;
  logic [AW-1:0] m0_PADDR;
  logic [DW-1:0] m0_PWDATA, m0_PRDATA;
  logic          m1_PSEL, m1_PENABLE, m1_PWRITE, m1_PREADY, m1_PSLVERR;
  logic [AW-1:0] m1_PADDR;
  logic [DW-1:0] m1_PWDATA, m1_PRDATA;
  logic          s_PSEL, s_PENABLE, s_PWRITE, s_PREADY;
  logic [AW-1:0] s_PADDR;
  logic [DW-1:0] s_PWDATA, s_PRDATA;

  apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .m0_PSEL(m0_PSEL), .m0_PENABLE(m0_PENABLE), .m0_PWRITE(m0_PWRITE),
    .m0_PADDR(m0_PADDR), .m0_PWDATA(m0_PWDATA), .m0_PRDATA(m0_PRDATA),
    .m0_PREADY(m0_PREADY), .m0_PSLVERR(m0_PSLVERR),
    .m1_PSEL(m1_PSEL), .m1_PENABLE(m1_PENABLE), .m1_PWRITE(m1_PWRITE),
    .m1_PADDR(m1_PADDR), .m1_PWDATA(m1_PWDATA), .m1_PRDATA(m1_PRDATA),
    .m1_PREADY(m1_PREADY), .m1_PSLVERR(m1_PSLVERR),
    .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE),
    .s_PADDR(s_PADDR), .s_PWDATA(s_PWDATA), .s_PRDATA(s_PRDATA), .s_PREADY(s_PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct { int m; int cyc; logic [DW-1:0] rd; logic err; } comp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] wd; logic wr; } setup_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_k, cur_w, viol, slv_hs, ref_last;
  bit pend[2];
  int age[2];
  logic [AW-1:0] maddr[2];
  logic [DW-1:0] mwd[2];
  logic          mwr[2];
  logic [DW-1:0] cur_d;
  int            wq[$];
  logic [DW-1:0] dq[$];
  comp_t         comps[$];
  setup_t        setups[$];

  function automatic logic [35:0] all_out();
    return {m0_PRDATA, m0_PREADY, m0_PSLVERR, m1_PRDATA, m1_PREADY, m1_PSLVERR,
            s_PSEL, s_PENABLE, s_PWRITE, s_PADDR, s_PWDATA};
  endfunction

  function automatic int eff(input int w);
    return (w >= TO) ? TO : w;
  endfunction

  // One clock: requesters drive, slave responds with its queued wait/data, responses logged.
  task automatic step();
    @(negedge PCLK);
    cyc++;
    for (int m = 0; m < 2; m++) age[m] = pend[m] ? age[m] + 1 : 0;
    m0_PSEL = pend[0]; m0_PENABLE = pend[0] && (age[0] > 1);
    m0_PADDR = maddr[0]; m0_PWDATA = mwd[0]; m0_PWRITE = mwr[0];
    m1_PSEL = pend[1]; m1_PENABLE = pend[1] && (age[1] > 1);
    m1_PADDR = maddr[1]; m1_PWDATA = mwd[1]; m1_PWRITE = mwr[1];
    #1;
    if (s_PSEL && !s_PENABLE) begin
      cur_w = (wq.size() > 0) ? wq.pop_front() : 0;
      cur_d = (dq.size() > 0) ? dq.pop_front() : '0;
      setups.push_back('{s_PADDR, s_PWDATA, s_PWRITE});
      acc_k = 0;
    end
    if (s_PSEL && s_PENABLE) acc_k++;
    s_PREADY = s_PSEL && s_PENABLE && (acc_k == cur_w + 1);
    s_PRDATA = s_PREADY ? cur_d : DW'($urandom);
    if (s_PREADY) slv_hs++;
    #1;
    if (m0_PREADY && m1_PREADY) viol++;
    if (!m0_PREADY && (m0_PRDATA != 0 || m0_PSLVERR)) viol++;
    if (!m1_PREADY && (m1_PRDATA != 0 || m1_PSLVERR)) viol++;
    if (m0_PREADY) begin
      if (!pend[0]) viol++;
      comps.push_back('{0, cyc, m0_PRDATA, m0_PSLVERR});
      pend[0] = 0;
    end
    if (m1_PREADY) begin
      if (!pend[1]) viol++;
      comps.push_back('{1, cyc, m1_PRDATA, m1_PSLVERR});
      pend[1] = 0;
    end
  endtask

  task automatic clear_engine();
    pend[0] = 0; pend[1] = 0;
    wq.delete(); dq.delete(); comps.delete(); setups.delete();
    acc_k = 0; cur_w = 0; s_PREADY = 0;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    clear_engine();
    repeat (3) step();
    PRESETn = 1'b1;
    ref_last = 1;
    step();
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    clear_engine();
    step();
    n_cmp++;
    if (all_out() !== 36'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h need 0", all_out());
    end
    PRESETn = 1'b1;
    ref_last = 1;
    repeat (2) step();
    n_cmp++;
    if (all_out() !== 36'h0) begin
      n_bad++; $display("FAIL idle_after_release: got %h need 0", all_out());
    end
  endtask

  task automatic test_single_write();
    int c;
    clear_engine();
    maddr[0] = 5'h03; mwd[0] = 8'hA5; mwr[0] = 1'b1; pend[0] = 1;
    wq.push_back(0); dq.push_back(8'h5A);
    step(); c = cyc;
    step();
    n_cmp++;
    if ({s_PSEL, s_PENABLE} !== 2'b10) begin
      n_bad++; $display("FAIL wr_setup_phase: sel/en %b need 10", {s_PSEL, s_PENABLE});
    end
    n_cmp++;
    if (s_PADDR !== 5'h03 || s_PWDATA !== 8'hA5 || s_PWRITE !== 1'b1 || m0_PREADY !== 1'b0) begin
      n_bad++; $display("FAIL wr_setup_bus: addr %h wd %h wr %b rdy %b need 03 a5 1 0",
                        s_PADDR, s_PWDATA, s_PWRITE, m0_PREADY);
    end
    step();
    n_cmp++;
    if ({s_PSEL, s_PENABLE} !== 2'b11 || s_PWDATA !== 8'hA5 || s_PADDR !== 5'h03) begin
      n_bad++; $display("FAIL wr_access: sel/en %b wd %h addr %h need 11 a5 03",
                        {s_PSEL, s_PENABLE}, s_PWDATA, s_PADDR);
    end
    n_cmp++;
    if (comps.size() != 1 || cyc != c + 2 || m0_PREADY !== 1'b1 || m0_PSLVERR !== 1'b0) begin
      n_bad++; $display("FAIL wr_done: n %0d cycle %0d rdy %b err %b need 1 %0d 1 0",
                        comps.size(), cyc - c, m0_PREADY, m0_PSLVERR, 2);
    end
    step();
    n_cmp++;
    if (s_PSEL !== 1'b0 || m0_PREADY !== 1'b0) begin
      n_bad++; $display("FAIL wr_back_idle: sel %b rdy %b need 0 0", s_PSEL, m0_PREADY);
    end
    ref_last = 0;
  endtask

  // Issues the given request pattern and checks order, timing, data and slave bus
  // against a transaction-level prediction.
  task automatic run_pattern(input string tag, input int pat, input int w0, input int w1);
    int c, first, second, t1, t2, nexp, v0;
    int w[2];
    logic [DW-1:0] d[2];
    int order[2];
    clear_engine();
    w[0] = w0; w[1] = w1;
    for (int m = 0; m < 2; m++) begin
      maddr[m] = AW'($urandom); mwd[m] = DW'($urandom); mwr[m] = 1'($urandom);
      d[m] = DW'($urandom);
    end
    if (pat == 3) first = (ref_last == 0) ? 1 : 0;
    else          first = (pat == 1) ? 0 : 1;
    second = 1 - first;
    order[0] = first; order[1] = second;
    nexp = (pat == 3) ? 2 : 1;
    for (int i = 0; i < nexp; i++) begin
      wq.push_back(w[order[i]]); dq.push_back(d[order[i]]);
    end
    pend[0] = pat[0]; pend[1] = pat[1];
    v0 = viol;
    step(); c = cyc;
    t1 = c + 2 + eff(w[first]);
    t2 = (nexp == 2) ? t1 + 3 + eff(w[second]) : t1;
    while (cyc < t2 + 1) step();
    n_cmp++;
    if (comps.size() != nexp || setups.size() != nexp) begin
      n_bad++; $display("FAIL %s_count: done %0d setups %0d need %0d", tag,
                        comps.size(), setups.size(), nexp);
    end else begin
      for (int i = 0; i < nexp; i++) begin
        int m, tx;
        logic [DW-1:0] erd;
        logic eerr;
        m = order[i];
        tx = (i == 0) ? t1 : t2;
        eerr = (w[m] >= TO);
        erd = eerr ? '0 : d[m];
        n_cmp++;
        if (comps[i].m != m || comps[i].cyc != tx || comps[i].rd !== erd || comps[i].err !== eerr) begin
          n_bad++; $display("FAIL %s_resp%0d: m%0d cyc %0d rd %h err %b need m%0d cyc %0d rd %h err %b",
                            tag, i, comps[i].m, comps[i].cyc - c, comps[i].rd, comps[i].err,
                            m, tx - c, erd, eerr);
        end
        n_cmp++;
        if (setups[i].addr !== maddr[m] || setups[i].wd !== mwd[m] || setups[i].wr !== mwr[m]) begin
          n_bad++; $display("FAIL %s_slave%0d: addr %h wd %h wr %b need %h %h %b", tag, i,
                            setups[i].addr, setups[i].wd, setups[i].wr, maddr[m], mwd[m], mwr[m]);
        end
      end
    end
    n_cmp++;
    if (viol != v0) begin
      n_bad++; $display("FAIL %s_idle_master: %0d stray response cycles need 0", tag, viol - v0);
    end
    ref_last = (nexp == 2) ? second : first;
  endtask

  task automatic test_rr_tie();
    do_reset();
    run_pattern("tie_a", 3, 0, 1);
    run_pattern("tie_b", 3, 2, 0);
    n_cmp++;
    if (ref_last != 1) begin
      n_bad++; $display("FAIL tie_last: last served m%0d need m1", ref_last);
    end
  endtask

  task automatic test_read_waits();
    int c, v0;
    clear_engine();
    maddr[1] = 5'h1F; mwd[1] = 8'h00; mwr[1] = 1'b0; pend[1] = 1;
    wq.push_back(4); dq.push_back(8'h3C);
    v0 = viol;
    step(); c = cyc;
    while (cyc < c + 7) step();
    n_cmp++;
    if (comps.size() != 1 || setups.size() != 1) begin
      n_bad++; $display("FAIL rd_count: done %0d need 1", comps.size());
    end else begin
      n_cmp++;
      if (comps[0].m != 1 || comps[0].cyc != c + 6 || comps[0].rd !== 8'h3C || comps[0].err !== 1'b0) begin
        n_bad++; $display("FAIL rd_resp: m%0d cyc %0d rd %h err %b need m1 6 3c 0",
                          comps[0].m, comps[0].cyc - c, comps[0].rd, comps[0].err);
      end
      n_cmp++;
      if (setups[0].addr !== 5'h1F || setups[0].wr !== 1'b0) begin
        n_bad++; $display("FAIL rd_slave: addr %h wr %b need 1f 0", setups[0].addr, setups[0].wr);
      end
    end
    n_cmp++;
    if (viol != v0) begin
      n_bad++; $display("FAIL rd_m0_quiet: %0d stray cycles need 0", viol - v0);
    end
    ref_last = 1;
  endtask

  task automatic test_timeout();
    int c;
    clear_engine();
    maddr[0] = 5'h11; mwd[0] = 8'h77; mwr[0] = 1'b1; pend[0] = 1;
    wq.push_back(1000); dq.push_back(8'hEE);
    step(); c = cyc;
    while (cyc < c + 2 + TO - 1) step();
    n_cmp++;
    if ({s_PSEL, s_PENABLE} !== 2'b11 || m0_PREADY !== 1'b0) begin
      n_bad++; $display("FAIL to_waiting: sel/en %b rdy %b need 11 0", {s_PSEL, s_PENABLE}, m0_PREADY);
    end
    step();
    n_cmp++;
    if (s_PSEL !== 1'b0 || m0_PREADY !== 1'b1 || m0_PRDATA !== 8'h00 || m0_PSLVERR !== 1'b1) begin
      n_bad++; $display("FAIL to_forced: sel %b rdy %b rd %h err %b need 0 1 00 1",
                        s_PSEL, m0_PREADY, m0_PRDATA, m0_PSLVERR);
    end
    step();
    n_cmp++;
    if (all_out() !== 36'h0) begin
      n_bad++; $display("FAIL to_idle: outputs %h need 0", all_out());
    end
    ref_last = 0;
  endtask

  task automatic test_reset_mid();
    clear_engine();
    maddr[0] = 5'h0A; mwd[0] = 8'h12; mwr[0] = 1'b1; pend[0] = 1;
    wq.push_back(1000); dq.push_back(8'h34);
    repeat (4) step();
    PRESETn = 1'b0;
    #1;
    n_cmp++;
    if (all_out() !== 36'h0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got %h need 0", all_out());
    end
    clear_engine();
    repeat (2) step();
    PRESETn = 1'b1;
    ref_last = 1;
    repeat (5) step();
    n_cmp++;
    if (comps.size() != 0 || setups.size() != 0) begin
      n_bad++; $display("FAIL rst_mid_no_resume: done %0d setups %0d need 0 0", comps.size(), setups.size());
    end
    run_pattern("post_rst", 2, 0, 2);
  endtask

  task automatic test_drop();
    int c, h0, v0;
    logic [DW-1:0] d1;
    clear_engine();
    d1 = DW'($urandom);
    maddr[0] = 5'h05; mwd[0] = 8'h55; mwr[0] = 1'b1;
    maddr[1] = 5'h16; mwd[1] = 8'h66; mwr[1] = 1'b0;
    wq.push_back(3); dq.push_back(8'h99);
    wq.push_back(1); dq.push_back(d1);
    h0 = slv_hs; v0 = viol;
    pend[0] = 1;
    step(); c = cyc;
    pend[1] = 1;
    step();
    step();
    pend[0] = 0;
    while (cyc < c + 10) step();
    n_cmp++;
    if (slv_hs - h0 != 2) begin
      n_bad++; $display("FAIL drop_slave_done: %0d handshakes need 2", slv_hs - h0);
    end
    n_cmp++;
    if (comps.size() != 1) begin
      n_bad++; $display("FAIL drop_count: %0d responses need 1", comps.size());
    end else begin
      n_cmp++;
      if (comps[0].m != 1 || comps[0].cyc != c + 9 || comps[0].rd !== d1 || comps[0].err !== 1'b0) begin
        n_bad++; $display("FAIL drop_m1_resp: m%0d cyc %0d rd %h err %b need m1 9 %h 0",
                          comps[0].m, comps[0].cyc - c, comps[0].rd, comps[0].err, d1);
      end
    end
    n_cmp++;
    if (setups.size() != 2 || setups[0].addr !== 5'h05 || setups[1].addr !== 5'h16) begin
      n_bad++; $display("FAIL drop_slave_order: setups %0d need 2 (05 then 16)", setups.size());
    end
    n_cmp++;
    if (viol != v0) begin
      n_bad++; $display("FAIL drop_m0_quiet: %0d stray cycles need 0", viol - v0);
    end
    ref_last = 1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int pat, w0, w1;
      pat = $urandom_range(1, 3);
      w0 = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
      w1 = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
      run_pattern("rand", pat, w0, w1);
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  initial begin
    PRESETn = 1'b0;
    s_PREADY = 1'b0; s_PRDATA = '0;
    acc_k = 0; cur_w = 0; viol = 0; slv_hs = 0; ref_last = 1; cur_d = '0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0; age[m] = 0; maddr[m] = '0; mwd[m] = '0; mwr[m] = 1'b0;
    end
    m0_PSEL = 0; m0_PENABLE = 0; m0_PWRITE = 0; m0_PADDR = '0; m0_PWDATA = '0;
    m1_PSEL = 0; m1_PENABLE = 0; m1_PWRITE = 0; m1_PADDR = '0; m1_PWDATA = '0;
    test_reset();
    test_single_write();
    test_rr_tie();
    test_read_waits();
    test_timeout();
    test_reset_mid();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
